// File: rtl/psg_env_gen.sv
// PSG envelope generator: steps a 2^ENV_W ramp on each sampled rising edge of the
// envelope-period divider output, shaped by the latched CONT/ATT/ALT/HOLD bits.
module psg_env_gen #(
  parameter int ENV_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             div_in,
  input  logic [3:0]       shape,
  input  logic             restart,
  output logic [ENV_W-1:0] env,
  output logic             held
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [ENV_W-1:0] CNT_MAX = {ENV_W{1'b1}};

  state_t           state, state_nx;
  logic [ENV_W-1:0] cnt, cnt_nx;
  logic             inv, inv_nx;
  logic             div_l, div_l_nx;
  // ATT only matters at restart (it seeds inv), so only CONT/ALT/HOLD are kept.
  logic [2:0]       shape_r, shape_r_nx;
  logic [ENV_W-1:0] hold_val, hold_val_nx;
  logic [ENV_W-1:0] env_nx;
  logic             held_nx;
  logic             step;

  assign step = cen & div_in & ~div_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HOLD;
      cnt      <= '0;
      inv      <= 1'b0;
      div_l    <= 1'b0;
      shape_r  <= '0;
      hold_val <= '0;
      env      <= '0;
      held     <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      inv      <= inv_nx;
      div_l    <= div_l_nx;
      shape_r  <= shape_r_nx;
      hold_val <= hold_val_nx;
      env      <= env_nx;
      held     <= held_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    inv_nx      = inv;
    div_l_nx    = cen ? div_in : div_l;
    shape_r_nx  = shape_r;
    hold_val_nx = hold_val;

    if (restart) begin
      shape_r_nx = {shape[3], shape[1], shape[0]};
      cnt_nx     = '0;
      inv_nx     = ~shape[2];
      state_nx   = RUN;
    end else if (step && state == RUN) begin
      // End of ramp is detected explicitly; the counter is never allowed to wrap.
      if (cnt != CNT_MAX) begin
        cnt_nx = cnt + ENV_W'(1);
      end else if (!shape_r[2]) begin
        state_nx    = HOLD;
        hold_val_nx = '0;
      end else if (shape_r[0]) begin
        state_nx    = HOLD;
        hold_val_nx = (cnt ^ {ENV_W{inv}}) ^ {ENV_W{shape_r[1]}};
      end else if (shape_r[1]) begin
        cnt_nx = '0;
        inv_nx = ~inv;
      end else begin
        cnt_nx = '0;
      end
    end

    env_nx  = (state_nx == HOLD) ? hold_val_nx : (cnt_nx ^ {ENV_W{inv_nx}});
    held_nx = (state_nx == HOLD);
  end

endmodule
